instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Boot-time loader directly upstream of the instruction RAM's write port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives data / writeAddr / we into the instruction RAM at consecutive addresses from 0, then verifies an XOR checksum.
- Holds the processor (cpu_hold) until the load completes or fails.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, instruction RAM address width; must be ≤ 16.
- BYTE_WIDTH, 8, width of the input stream symbol.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  begin a new load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  BYTE_WIDTH  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- data  output  DATA_WIDTH  word to the instruction RAM.
- writeAddr  output  ADDR_WIDTH  RAM write address.
- we  output  1  RAM write enable, one-cycle pulse per word.
- cpu_hold  output  1  high while a load is in progress.
- done  output  1  sticky flag: load completed with a good checksum.
- error  output  1  sticky flag: length overflow or checksum mismatch.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; all counters, checksum and assembly register cleared. Reset mid-load abandons the load immediately and we drops with RST.
- Accept = byte_valid && byte_ready. byte_ready=1 only in LEN_LO, LEN_HI, WORD and CHECK; 0 in all other states.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then N×4 bytes (each word LSB first), then one checksum byte.
- Checksum byte must equal the XOR of every preceding frame byte, length bytes included.
- States and transitions:
  - IDLE: start → LEN_LO; clears the checksum, words_loaded, done and error; sets cpu_hold=1.
  - LEN_LO: on accept, latch the low length byte → LEN_HI.
  - LEN_HI: on accept, form N.
    - N > 2**ADDR_WIDTH → ERROR; no write occurs.
    - N == 0 → CHECK.
    - Otherwise → WORD with byte index 0.
  - WORD: on accept, shift the byte into the assembly register at position index*8 and increment index (0..3). When the 4th byte is accepted → WRITE.
  - WRITE (exactly 1 cycle): we=1; data=assembled word; writeAddr=words_loaded[ADDR_WIDTH-1:0].
    - On exit, words_loaded increments.
    - Then, if words_loaded+1 == N → CHECK, else → WORD.
  - CHECK: on accept, compare the byte with the running XOR; equal → DONE, else → ERROR.
  - DONE: done=1, cpu_hold=0; start → new load.
  - ERROR: error=1, cpu_hold=0; start → new load.
- Latency: the we pulse occurs on the cycle after the 4th byte of a word is accepted.
- data and writeAddr hold their last value between pulses. All writes are issued on posedge and are stable across the RAM's negedge write edge.
- start outside IDLE/DONE/ERROR is ignored.
- byte_valid outside accepting states is ignored; no byte is consumed.
- Words already written before an ERROR remain in RAM; the loader does not roll back.
- The running checksum is updated on every accepted byte except the checksum byte itself.

Decomposition:
- Shared package instr_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, WORD, WRITE, CHECK, DONE, ERROR;
  - BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH;
  - LEN_BYTES = 2.
- One sub-module, loader_word_pack: the byte-to-word assembly register plus byte index. It takes a load strobe and a clear, and outputs the assembled word and a word_full flag.
- The FSM, counters and checksum stay in instr_loader.

Test Plan:
- Single word: start; bytes 01 00 EF BE AD DE 23 with byte_valid held high → one we pulse with data=0xDEADBEEF, writeAddr=0; done=1, error=0, words_loaded=1, cpu_hold falls after the checksum.
- Empty image: bytes 00 00 00 → no we pulse; done=1; byte_ready low after the checksum is accepted.
- Overflow: bytes 01 04 (N=1025) → error=1 the cycle after the 2nd byte; no we pulse; byte_ready=0; further bytes are ignored.
- Bad checksum: bytes 01 00 78 56 34 12 FF → we pulse with data=0x12345678 at address 0, then error=1, done=0.
- Backpressure and multiword: N=3 with random byte_valid gaps → we pulses at addresses 0, 1, 2 in order; byte_ready=0 in each WRITE cycle; correct words and done=1.
- Reset mid-load: assert RST after the 2nd byte of word 1 → all outputs 0 immediately. A subsequent start and a full valid frame loads correctly from address 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, WORD, WRITE, CHECK, DONE, ERROR
   } state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BYTE_WIDTH = 8;
   localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;
   localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/instr_loader_word_pack.sv
// Little-endian byte-to-word assembly register with its byte index.
module loader_word_pack
   import instr_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
   parameter int NBYTES     = BYTES_PER_WORD
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  clr_i,
   input  logic [BYTE_WIDTH-1:0] byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_full_o
);

   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

   logic [DATA_WIDTH-1:0] word_q;
   logic [IDX_W-1:0]      idx_q;

   // Asserted on the load that completes the word, so the FSM can leave WORD on that edge.
   assign word_full_o = load_i && (idx_q == LAST);
   assign word_o      = word_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (clr_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (load_i) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) word_q[i*BYTE_WIDTH +: BYTE_WIDTH] <= byte_i;
         end
         idx_q <= (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length-prefixed byte frame, writes words to instruction RAM,
// verifies the trailing XOR checksum and holds the CPU until the load resolves.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic [ADDR_WIDTH-1:0] writeAddr,
   output logic                  we,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
   localparam int LEN_W = LEN_BYTES * BYTE_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [LEN_W:0] MAX_WORDS =
      {{(LEN_W - ADDR_WIDTH){1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                state_q, state_d;
   logic [BYTE_WIDTH-1:0] len_lo_q;
   logic [LEN_W-1:0]      len_q;
   logic [BYTE_WIDTH-1:0] csum_q;
   logic [CNT_W-1:0]      words_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic                  accept;
   logic                  start_load;
   logic                  pack_load;
   logic                  pack_full;
   logic [DATA_WIDTH-1:0] pack_word;
   logic [LEN_W-1:0]      n_now;
   logic [CNT_W-1:0]      words_nxt;
   logic [LEN_W:0]        words_nxt_ext;

   assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == WORD)   || (state_q == CHECK);
   assign accept     = byte_valid && byte_ready;
   assign start_load = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
   assign pack_load  = accept && (state_q == WORD);

   assign n_now         = {byte_in, len_lo_q};
   assign words_nxt     = words_q + CNT_W'(1);
   assign words_nxt_ext = {{(LEN_W - ADDR_WIDTH){1'b0}}, words_nxt};

   loader_word_pack #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .NBYTES     (BPW)
   ) u_pack (
      .clk_i       (CLK),
      .rst_i       (RST),
      .load_i      (pack_load),
      .clr_i       (start_load),
      .byte_i      (byte_in),
      .word_o      (pack_word),
      .word_full_o (pack_full)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start_load) state_d = LEN_LO;
         LEN_LO:            if (accept) state_d = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if ({1'b0, n_now} > MAX_WORDS) state_d = ERROR;
               else if (n_now == '0)          state_d = CHECK;
               else                           state_d = WORD;
            end
         end
         WORD:              if (pack_full) state_d = WRITE;
         WRITE:             state_d = (words_nxt_ext == {1'b0, len_q}) ? CHECK : WORD;
         CHECK: begin
            if (accept) state_d = (byte_in == csum_q) ? DONE : ERROR;
         end
         default:           state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         csum_q   <= '0;
         words_q  <= '0;
         data_q   <= '0;
         addr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (start_load) begin
            csum_q  <= '0;
            words_q <= '0;
         end
         // The checksum byte itself is compared, never folded in.
         if (accept && (state_q != CHECK)) csum_q <= csum_q ^ byte_in;
         if (accept && (state_q == LEN_LO)) len_lo_q <= byte_in;
         if (accept && (state_q == LEN_HI)) len_q <= n_now;
         if (state_q == WRITE) begin
            words_q <= words_nxt;
            data_q  <= pack_word;
            addr_q  <= words_q[ADDR_WIDTH-1:0];
         end
      end
   end

   // During WRITE the live word/address are presented; afterwards the held copies.
   assign we           = (state_q == WRITE);
   assign data         = we ? pack_word : data_q;
   assign writeAddr    = we ? words_q[ADDR_WIDTH-1:0] : addr_q;
   assign cpu_hold     = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
   assign done         = (state_q == DONE);
   assign error        = (state_q == ERROR);
   assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame vectors table plus write scoreboard.
module tb_instr_loader;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] data;
   logic [9:0]  writeAddr;
   logic        we;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [10:0] words_loaded;

   instr_loader dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .data         (data),
      .writeAddr    (writeAddr),
      .we           (we),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passes = 0;
   logic [41:0] exp_q [$];

   typedef struct {
      string      name;
      int         off;
      int         nb;
      int         csum_mode;  // 0: none sent, 1: explicit, 2: computed XOR
      logic [7:0] csum;
      int         gap_max;
      logic       exp_done;
      logic       exp_err;
      int         exp_words;
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] pool [0:29];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge CLK) begin
      if (!RST && we) begin
         chk("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_we", {22'd0, writeAddr, data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            chk("write_addr_data", {22'd0, writeAddr, data}, {22'd0, e});
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int cnt;
      if (gap_max > 0) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(gap_max, 0)) begin @(posedge CLK); #1; end
      end
      byte_in    = b;
      byte_valid = 1'b1;
      cnt = 0;
      while (!byte_ready && cnt < 200) begin
         @(posedge CLK); #1;
         cnt++;
      end
      if (cnt >= 200) begin
         chk("ready_timeout", 64'd0, 64'd1);
         return;
      end
      @(posedge CLK); #1;
   endtask

   task automatic run_frame(input int vi);
      vec_t       v;
      logic [7:0] fb [$];
      logic [7:0] x;
      logic [31:0] w;
      int n;
      v = vecs[vi];
      x = 8'h00;
      for (int i = 0; i < v.nb; i++) begin
         fb.push_back(pool[v.off + i]);
         x = x ^ pool[v.off + i];
      end
      if (v.csum_mode == 1) fb.push_back(v.csum);
      if (v.csum_mode == 2) fb.push_back(x);
      n = {16'd0, fb[1], fb[0]};
      if (n <= 1024) begin
         for (int k = 0; k < n; k++) begin
            w = {fb[2+4*k+3], fb[2+4*k+2], fb[2+4*k+1], fb[2+4*k]};
            exp_q.push_back({10'(k), w});
         end
      end
      do_start();
      chk({v.name, "_hold"}, {63'd0, cpu_hold}, 64'd1);
      for (int i = 0; i < fb.size(); i++) begin
         send_byte(fb[i], v.gap_max);
         if (n <= 1024 && i >= 2 && i < 2 + 4*n && ((i - 2) % 4) == 3)
            chk({v.name, "_we_latency"}, {63'd0, we}, 64'd1);
      end
      byte_valid = 1'b0;
      chk({v.name, "_done"},   {63'd0, done},  {63'd0, v.exp_done});
      chk({v.name, "_error"},  {63'd0, error}, {63'd0, v.exp_err});
      chk({v.name, "_words"},  {53'd0, words_loaded}, 64'(v.exp_words));
      chk({v.name, "_release"}, {63'd0, cpu_hold}, 64'd0);
      chk({v.name, "_ready_off"}, {63'd0, byte_ready}, 64'd0);
      chk({v.name, "_all_written"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      pool = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h00, 8'h00,
               8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'h03, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
               8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
               8'h01, 8'h04};
      vecs[0] = '{"single",   0,  6, 1, 8'h23, 0, 1'b1, 1'b0, 1};
      vecs[1] = '{"empty",    6,  2, 1, 8'h00, 0, 1'b1, 1'b0, 0};
      vecs[2] = '{"badsum",   8,  6, 1, 8'hFF, 0, 1'b0, 1'b1, 1};
      vecs[3] = '{"multi",   14, 14, 2, 8'h00, 3, 1'b1, 1'b0, 3};
      vecs[4] = '{"overflow", 28, 2, 0, 8'h00, 0, 1'b0, 1'b1, 0};

      RST = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      #12;
      chk("rst_we",     {63'd0, we}, 64'd0);
      chk("rst_data",   {32'd0, data}, 64'd0);
      chk("rst_addr",   {54'd0, writeAddr}, 64'd0);
      chk("rst_hold",   {63'd0, cpu_hold}, 64'd0);
      chk("rst_done",   {63'd0, done}, 64'd0);
      chk("rst_error",  {63'd0, error}, 64'd0);
      chk("rst_words",  {53'd0, words_loaded}, 64'd0);
      chk("rst_ready",  {63'd0, byte_ready}, 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;

      for (int vi = 0; vi < 4; vi++) run_frame(vi);

      // Abandon a load partway through the first word, then reload cleanly.
      do_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      byte_valid = 1'b0;
      #2 RST = 1'b1;
      #1;
      chk("midrst_hold",  {63'd0, cpu_hold}, 64'd0);
      chk("midrst_data",  {32'd0, data}, 64'd0);
      chk("midrst_addr",  {54'd0, writeAddr}, 64'd0);
      chk("midrst_words", {53'd0, words_loaded}, 64'd0);
      chk("midrst_ready", {63'd0, byte_ready}, 64'd0);
      chk("midrst_we",    {63'd0, we}, 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      run_frame(0);

      run_frame(4);
      byte_valid = 1'b1;
      byte_in    = 8'h55;
      repeat (3) begin
         @(posedge CLK); #1;
         chk("ovf_ignored_ready", {63'd0, byte_ready}, 64'd0);
      end
      byte_valid = 1'b0;
      chk("ovf_error_sticky", {63'd0, error}, 64'd1);
      chk("ovf_words",        {53'd0, words_loaded}, 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
